// File: rtl/counter_pkg.sv
// Shared types and helpers for the parametrised binary counters.
// Imported by the counter top and its terminal-detect block.
package counter_pkg;

    typedef enum logic {
        WRAP = 1'b0,
        SAT  = 1'b1
    } cnt_mode_e;

    localparam int CNT_WIDTH_MIN = 2;
    localparam int CNT_WIDTH_MAX = 32;

    // Terminal value depends on direction: MAX_VAL going up, 0 going down.
    function automatic logic at_term(
        input logic up,
        input logic at_max,
        input logic at_zero
    );
        return up ? at_max : at_zero;
    endfunction

endpackage

// File: rtl/cnt_term_detect.sv
// Terminal-count compare and cascade carry/borrow for the counter.
// Purely combinational so C_out can feed the next stage on the same edge.
module cnt_term_detect
    import counter_pkg::*;
#(
    parameter int             WIDTH   = 8,
    parameter logic [WIDTH-1:0] MAX_VAL = '1
) (
    input  logic [WIDTH-1:0] cnt_val,
    input  logic             count,
    input  logic             load,
    input  logic             clear,
    input  logic             up,
    output logic             at_max,
    output logic             at_zero,
    output logic             c_out
);

    assign at_max  = (cnt_val == MAX_VAL);
    assign at_zero = (cnt_val == '0);

    assign c_out = count && !load && !clear
                && at_term(up, at_max, at_zero);

endmodule

// File: rtl/binary_counter_par_load_ud.sv
// Width/modulus-configurable up/down counter with parallel load,
// wrap-or-saturate terminal behaviour and a sticky overflow flag.
module binary_counter_par_load_ud
    import counter_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] MAX_VAL  = '1,
    parameter bit               SATURATE = 1'b0
) (
    input  logic             CLK,
    input  logic             Clear,
    input  logic [WIDTH-1:0] Data_in,
    input  logic             Load,
    input  logic             Count,
    input  logic             Up,
    input  logic             Ovf_clr,
    output logic [WIDTH-1:0] A_count,
    output logic             C_out,
    output logic             Ovf
);

    localparam cnt_mode_e MODE = SATURATE ? SAT : WRAP;

    if (WIDTH < CNT_WIDTH_MIN || WIDTH > CNT_WIDTH_MAX) begin : g_bad_width
        $error("binary_counter_par_load_ud: WIDTH out of range");
    end

    if (MAX_VAL == '0) begin : g_bad_max
        $error("binary_counter_par_load_ud: MAX_VAL must be nonzero");
    end

    logic             at_max;
    logic             at_zero;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] inc_val;
    logic [WIDTH-1:0] dec_val;
    logic [WIDTH-1:0] cnt_nxt;
    logic             ovf_nxt;

    cnt_term_detect #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL)
    ) u_term (
        .cnt_val (A_count),
        .count   (Count),
        .load    (Load),
        .clear   (Clear),
        .up      (Up),
        .at_max  (at_max),
        .at_zero (at_zero),
        .c_out   (C_out)
    );

    // Arithmetic is modulo MAX_VAL+1, so wrap targets are 0 / MAX_VAL.
    always_comb begin
        load_val = (Data_in > MAX_VAL) ? MAX_VAL : Data_in;

        if (at_max)
            inc_val = (MODE == SAT) ? MAX_VAL : '0;
        else
            inc_val = A_count + WIDTH'(1);

        if (at_zero)
            dec_val = (MODE == SAT) ? '0 : MAX_VAL;
        else
            dec_val = A_count - WIDTH'(1);

        if (Load)
            cnt_nxt = load_val;
        else if (Count)
            cnt_nxt = Up ? inc_val : dec_val;
        else
            cnt_nxt = A_count;

        if (C_out)
            ovf_nxt = 1'b1;
        else if (Ovf_clr)
            ovf_nxt = 1'b0;
        else
            ovf_nxt = Ovf;
    end

    always_ff @(posedge CLK) begin
        if (Clear) begin
            A_count <= '0;
            Ovf     <= 1'b0;
        end else begin
            A_count <= cnt_nxt;
            Ovf     <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_binary_counter_par_load_ud.sv
// Bench: three counter configurations on shared stimulus, each
// tracked by an arithmetic reference model; directed then random.
module tb_binary_counter_par_load_ud;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       clr, ld, cnt, up, oclr;
    logic [7:0] din;
    logic [7:0] a  [3];
    logic       co [3];
    logic       ov [3];

    int checks = 0;
    int errors = 0;

    int mx [3] = '{9, 9, 255};
    bit ms [3] = '{1'b0, 1'b1, 1'b0};
    int mc [3] = '{0, 0, 0};
    int mo [3] = '{0, 0, 0};

    binary_counter_par_load_ud #(
        .WIDTH(8), .MAX_VAL(8'd9), .SATURATE(1'b0)
    ) d0 (
        .CLK(CLK), .Clear(clr), .Data_in(din), .Load(ld),
        .Count(cnt), .Up(up), .Ovf_clr(oclr),
        .A_count(a[0]), .C_out(co[0]), .Ovf(ov[0])
    );

    binary_counter_par_load_ud #(
        .WIDTH(8), .MAX_VAL(8'd9), .SATURATE(1'b1)
    ) d1 (
        .CLK(CLK), .Clear(clr), .Data_in(din), .Load(ld),
        .Count(cnt), .Up(up), .Ovf_clr(oclr),
        .A_count(a[1]), .C_out(co[1]), .Ovf(ov[1])
    );

    binary_counter_par_load_ud #(
        .WIDTH(8), .MAX_VAL(8'd255), .SATURATE(1'b0)
    ) d2 (
        .CLK(CLK), .Clear(clr), .Data_in(din), .Load(ld),
        .Count(cnt), .Up(up), .Ovf_clr(oclr),
        .A_count(a[2]), .C_out(co[2]), .Ovf(ov[2])
    );

    function automatic bit exp_cout(int i);
        return cnt && !ld && !clr
            && (up ? (mc[i] == mx[i]) : (mc[i] == 0));
    endfunction

    function automatic int model_step(int i);
        int m = mx[i] + 1;
        if (ms[i])
            return up ? ((mc[i] < mx[i]) ? mc[i] + 1 : mx[i])
                      : ((mc[i] > 0) ? mc[i] - 1 : 0);
        return up ? (mc[i] + 1) % m : (mc[i] + mx[i]) % m;
    endfunction

    task automatic drive(bit c_, bit l_, bit n_, bit u_, bit o_,
                         logic [7:0] d_);
        clr = c_; ld = l_; cnt = n_; up = u_; oclr = o_; din = d_;
        #1;
    endtask

    task automatic tick();
        bit c [3];
        for (int i = 0; i < 3; i++) c[i] = exp_cout(i);
        @(posedge CLK);
        for (int i = 0; i < 3; i++) begin
            if (clr) begin
                mc[i] = 0;
                mo[i] = 0;
            end else begin
                if (ld)
                    mc[i] = (int'(din) > mx[i]) ? mx[i] : int'(din);
                else if (cnt)
                    mc[i] = model_step(i);
                if (c[i])
                    mo[i] = 1;
                else if (oclr)
                    mo[i] = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        drive(1, 1, 1, 1, 0, 8'd5);
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (a[i] !== 8'd0 || ov[i] !== 1'b0 || co[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset dut%0d a=%0d ovf=%b cout=%b want 0 0 0",
                         i, a[i], ov[i], co[i]);
            end
        end
        drive(0, 0, 1, 1, 0, 8'd0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if (a[0] !== 8'(k)) begin
                errors++;
                $display("FAIL reset_resume a=%0d want %0d", a[0], k);
            end
        end
    endtask

    task automatic test_wrap_up();
        drive(0, 1, 0, 1, 1, 8'd8);
        tick();
        checks++;
        if (a[0] !== 8'd8 || ov[0] !== 1'b0) begin
            errors++;
            $display("FAIL wrap_load a=%0d ovf=%b want 8 0", a[0], ov[0]);
        end
        drive(0, 0, 1, 1, 0, 8'd0);
        checks++;
        if (co[0] !== 1'b0) begin
            errors++;
            $display("FAIL wrap_cout8 got %b want 0", co[0]);
        end
        tick();
        checks++;
        if (a[0] !== 8'd9 || co[0] !== 1'b1 || ov[0] !== 1'b0) begin
            errors++;
            $display("FAIL wrap_at9 a=%0d cout=%b ovf=%b want 9 1 0",
                     a[0], co[0], ov[0]);
        end
        tick();
        checks++;
        if (a[0] !== 8'd0 || co[0] !== 1'b0 || ov[0] !== 1'b1) begin
            errors++;
            $display("FAIL wrap_to0 a=%0d cout=%b ovf=%b want 0 0 1",
                     a[0], co[0], ov[0]);
        end
        tick();
        checks++;
        if (a[0] !== 8'd1 || ov[0] !== 1'b1) begin
            errors++;
            $display("FAIL wrap_to1 a=%0d ovf=%b want 1 1", a[0], ov[0]);
        end
    endtask

    task automatic test_sat_down();
        drive(0, 1, 0, 0, 1, 8'd1);
        tick();
        checks++;
        if (a[1] !== 8'd1 || ov[1] !== 1'b0) begin
            errors++;
            $display("FAIL sat_load a=%0d ovf=%b want 1 0", a[1], ov[1]);
        end
        drive(0, 0, 1, 0, 0, 8'd0);
        checks++;
        if (co[1] !== 1'b0) begin
            errors++;
            $display("FAIL sat_cout1 got %b want 0", co[1]);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (a[1] !== 8'd0 || co[1] !== 1'b1
                || ov[1] !== (k > 0 ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL sat_hold%0d a=%0d cout=%b ovf=%b want 0 1 %0d",
                         k, a[1], co[1], ov[1], (k > 0) ? 1 : 0);
            end
        end
        drive(0, 0, 1, 0, 1, 8'd0);
        tick();
        checks++;
        if (ov[1] !== 1'b1) begin
            errors++;
            $display("FAIL sat_clr_while_count ovf=%b want 1", ov[1]);
        end
        drive(0, 0, 0, 0, 1, 8'd0);
        tick();
        checks++;
        if (ov[1] !== 1'b0 || a[1] !== 8'd0) begin
            errors++;
            $display("FAIL sat_clr ovf=%b a=%0d want 0 0", ov[1], a[1]);
        end
    endtask

    task automatic test_load_clamp();
        int o;
        drive(0, 1, 1, 1, 0, 8'd12);
        checks++;
        if (co[0] !== 1'b0) begin
            errors++;
            $display("FAIL clamp_cout got %b want 0", co[0]);
        end
        o = mo[0];
        tick();
        checks++;
        if (a[0] !== 8'd9 || ov[0] !== 1'(o)) begin
            errors++;
            $display("FAIL clamp a=%0d ovf=%b want 9 %0d", a[0], ov[0], o);
        end
        drive(1, 1, 1, 1, 0, 8'd12);
        checks++;
        if (co[0] !== 1'b0) begin
            errors++;
            $display("FAIL clear_cout got %b want 0", co[0]);
        end
        tick();
        checks++;
        if (a[0] !== 8'd0 || ov[0] !== 1'b0) begin
            errors++;
            $display("FAIL clear_over_load a=%0d ovf=%b want 0 0",
                     a[0], ov[0]);
        end
    endtask

    task automatic test_direction();
        bit pat [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        int exp [5] = '{6, 7, 6, 5, 4};
        drive(0, 1, 0, 1, 0, 8'd5);
        tick();
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 1, pat[k], 0, 8'd0);
            tick();
            checks++;
            if (a[2] !== 8'(exp[k])) begin
                errors++;
                $display("FAIL dir%0d a=%0d want %0d", k, a[2], exp[k]);
            end
        end
    endtask

    task automatic test_collision();
        drive(0, 1, 0, 1, 1, 8'd255);
        tick();
        checks++;
        if (a[2] !== 8'd255 || ov[2] !== 1'b0) begin
            errors++;
            $display("FAIL coll_load a=%0d ovf=%b want 255 0", a[2], ov[2]);
        end
        drive(0, 0, 1, 1, 1, 8'd0);
        checks++;
        if (co[2] !== 1'b1) begin
            errors++;
            $display("FAIL coll_cout got %b want 1", co[2]);
        end
        tick();
        checks++;
        if (a[2] !== 8'd0 || ov[2] !== 1'b1) begin
            errors++;
            $display("FAIL coll_set_wins a=%0d ovf=%b want 0 1", a[2], ov[2]);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            drive(($urandom % 32) == 0, ($urandom % 4) == 0,
                  ($urandom % 4) != 0, 1'($urandom), ($urandom % 8) == 0,
                  8'($urandom));
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (co[i] !== exp_cout(i)) begin
                    errors++;
                    $display("FAIL rnd_cout n=%0d dut%0d got %b want %b",
                             n, i, co[i], exp_cout(i));
                end
            end
            tick();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (a[i] !== 8'(mc[i]) || ov[i] !== 1'(mo[i])) begin
                    errors++;
                    $display("FAIL rnd_state n=%0d dut%0d a=%0d ovf=%b want %0d %0d",
                             n, i, a[i], ov[i], mc[i], mo[i]);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        drive(1, 0, 0, 1, 0, 8'd0);
        test_reset();
        test_wrap_up();
        test_sat_down();
        test_load_clamp();
        test_direction();
        test_collision();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
